// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and hold encodings for the pipeline hold/flush controller.
// Hold encodings are cumulative: a stage only holds when every younger stage also holds.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam int HOLD_IF  = 0;
  localparam int HOLD_ID  = 1;
  localparam int HOLD_MEM = 2;

  localparam logic [2:0] HOLD_NONE  = 3'b000;
  localparam logic [2:0] HOLD_FRONT = 3'b001;
  localparam logic [2:0] HOLD_EX    = 3'b011;
  localparam logic [2:0] HOLD_ALL   = 3'b111;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller signal bundle; slave = controller side, master = pipeline side.
// With HAZARD_STALL_CNT_EN defined the bundle also carries stall_cycles_o.
interface pipeline_hazard_ctrl_if;

  logic       mem_req_i;
  logic       mem_ack_i;
  logic       ex_busy_i;
  logic       ex_mem_read_i;
  logic [4:0] ex_rd_i;
  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic       id_use_rs1_i;
  logic       id_use_rs2_i;
  logic       branch_taken_i;
  logic [2:0] flag_hold;
  logic       flush_ifid_o;
  logic       flush_idex_o;
  logic       bus_req_o;
  logic       bus_err_o;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cycles_o;
`endif

  modport slave (
    input  mem_req_i, mem_ack_i, ex_busy_i, ex_mem_read_i, ex_rd_i,
           id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, branch_taken_i,
`ifdef HAZARD_STALL_CNT_EN
    output stall_cycles_o,
`endif
    output flag_hold, flush_ifid_o, flush_idex_o, bus_req_o, bus_err_o
  );

  modport master (
    output mem_req_i, mem_ack_i, ex_busy_i, ex_mem_read_i, ex_rd_i,
           id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, branch_taken_i,
`ifdef HAZARD_STALL_CNT_EN
    input  stall_cycles_o,
`endif
    input  flag_hold, flush_ifid_o, flush_idex_o, bus_req_o, bus_err_o
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_mem_wait_fsm.sv
// MEM-stage data-bus request/ack sequencer with wait-state timeout abort.
// Outputs are combinational (zero latency); mem_stall holds the whole pipe while waiting.
module mem_wait_fsm
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic sys_clk,
  input  logic sys_arstn,
  input  logic mem_req_i,
  input  logic mem_ack_i,
  output logic mem_stall,
  output logic bus_req_o,
  output logic bus_err_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             stall, req, err;

  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    req       = 1'b0;
    err       = 1'b0;
    unique case (state)
      RUN: begin
        req = mem_req_i;
        if (mem_req_i && !mem_ack_i) begin
          stall     = 1'b1;
          state_nxt = MEM_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        req = 1'b1;
        // Ack wins over timeout on the same cycle.
        if (mem_ack_i) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(MEM_TIMEOUT)) begin
          err       = 1'b1;
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          stall   = 1'b1;
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Gate with reset so an in-flight access is dropped immediately, without an error.
  assign mem_stall = sys_arstn & stall;
  assign bus_req_o = sys_arstn & req;
  assign bus_err_o = sys_arstn & err;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hold/flush controller: mem stall > EX busy > taken branch > load-use; outputs combinational.
// Optional HAZARD_STALL_CNT_EN adds a saturating count of cycles with any stage held.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  sys_clk,
  input  logic                  sys_arstn,
  pipeline_hazard_ctrl_if.slave hz
);

  logic       mem_stall;
  logic       lu;
  logic [2:0] hold;
  logic       fl_ifid, fl_idex;

  mem_wait_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_fsm (
    .sys_clk   (sys_clk),
    .sys_arstn (sys_arstn),
    .mem_req_i (hz.mem_req_i),
    .mem_ack_i (hz.mem_ack_i),
    .mem_stall (mem_stall),
    .bus_req_o (hz.bus_req_o),
    .bus_err_o (hz.bus_err_o)
  );

  always_comb begin
    lu = hz.ex_mem_read_i && (hz.ex_rd_i != 5'd0) &&
         ((hz.id_use_rs1_i && (hz.id_rs1_i == hz.ex_rd_i)) ||
          (hz.id_use_rs2_i && (hz.id_rs2_i == hz.ex_rd_i)));
  end

  always_comb begin
    hold    = HOLD_NONE;
    fl_ifid = 1'b0;
    fl_idex = 1'b0;
    if (mem_stall) begin
      hold = HOLD_ALL;
    end else if (hz.ex_busy_i) begin
      hold = HOLD_EX;
    end else if (hz.branch_taken_i) begin
      fl_ifid = 1'b1;
      fl_idex = 1'b1;
    end else if (lu) begin
      // Freeze IF/ID and PC, insert one bubble behind the load.
      hold    = HOLD_FRONT;
      fl_idex = 1'b1;
    end
  end

  assign hz.flag_hold    = sys_arstn ? hold : HOLD_NONE;
  assign hz.flush_ifid_o = sys_arstn & fl_ifid;
  assign hz.flush_idex_o = sys_arstn & fl_idex;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      stall_cnt <= '0;
    end else if ((hold != HOLD_NONE) && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign hz.stall_cycles_o = stall_cnt;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hold/flush controller for the 5-stage pipeline; drives the `flag_hold[2:0]` and flush inputs of every pipeline-register stage (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Resolves four conditions: data-bus wait states, multi-cycle EX busy, load-use hazards and taken branches.
- Sequences the MEM-stage data-bus request/acknowledge handshake with a timeout.

Parameters:
- MEM_TIMEOUT, 15, max wait cycles in MEM_WAIT before abort (>=1).
- CNT_W, $clog2(MEM_TIMEOUT+1), wait-counter width (derived, not overridden).

Ports:
- sys_clk  in  1  system clock, rising edge
- sys_arstn  in  1  asynchronous active-low reset
- mem_req_i  in  1  MEM-stage instruction is a load/store
- mem_ack_i  in  1  data bus completes access this cycle
- ex_busy_i  in  1  multi-cycle EX unit not finished
- ex_mem_read_i  in  1  EX-stage instruction is a load
- ex_rd_i  in  5  EX-stage destination register
- id_rs1_i  in  5  ID-stage source 1
- id_rs2_i  in  5  ID-stage source 2
- id_use_rs1_i  in  1  ID instruction reads rs1
- id_use_rs2_i  in  1  ID instruction reads rs2
- branch_taken_i  in  1  EX resolved taken branch/jump
- flag_hold  out  3  [0] PC+IF/ID hold, [1] ID/EX hold, [2] EX/MEM+MEM/WB hold
- flush_ifid_o  out  1  load bubble into IF/ID
- flush_idex_o  out  1  load bubble into ID/EX
- bus_req_o  out  1  data-bus request
- bus_err_o  out  1  one-cycle timeout abort pulse

Behaviour:
- Single clock `sys_clk`; reset `sys_arstn` is asynchronous and active-low.
- While `sys_arstn`=0: state=RUN, wait counter=0, and every output is forced to 0.
- All outputs are combinational from state, counter and inputs, so stage registers see them in the same cycle.
- FSM states are RUN and MEM_WAIT.
- RUN:
  - `bus_req_o` = `mem_req_i`.
  - If `mem_req_i` and `mem_ack_i`: zero-wait access, no mem stall, stay in RUN.
  - If `mem_req_i` and not `mem_ack_i`: mem stall this cycle, go to MEM_WAIT, counter<=1.
- MEM_WAIT:
  - `bus_req_o`=1 and mem stall asserted (`mem_req_i` is ignored).
  - On `mem_ack_i`: mem stall deasserted this cycle (pipeline advances), next state RUN, counter<=0.
  - Else if counter==MEM_TIMEOUT: `bus_err_o`=1, stall deasserted, next state RUN, counter<=0.
  - Else counter<=counter+1.
  - Ack on the timeout cycle counts as success: no error.
- Load-use hazard (lu) = `ex_mem_read_i` && `ex_rd_i`!=0 && ((`id_use_rs1_i` && `id_rs1_i`==`ex_rd_i`) || (`id_use_rs2_i` && `id_rs2_i`==`ex_rd_i`)).
- Priority, highest first:
  1. Mem stall: `flag_hold`=3'b111, no flushes. A pending branch or lu is held, not acted on.
  2. `ex_busy_i`: `flag_hold`=3'b011, `flush_*`=0; `branch_taken_i` is ignored while busy.
  3. `branch_taken_i`: `flag_hold`=3'b000, `flush_ifid_o`=1, `flush_idex_o`=1. Branch overrides lu.
  4. lu: `flag_hold`=3'b001, `flush_idex_o`=1 (one bubble); clears next cycle once the load moves to MEM.
  5. Otherwise all outputs 0.
- `flag_hold` is always one of 3'b000, 3'b001, 3'b011 or 3'b111. A lower stage never holds while a younger stage advances.
- Back-to-back memory ops: the ack cycle returns to RUN; the next cycle evaluates the new `mem_req_i` afresh.
- Reset asserted during MEM_WAIT aborts the access at once (`bus_req_o` drops asynchronously) with no `bus_err_o`.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined: adds output `stall_cycles_o` [31:0]; +1 on each cycle with `flag_hold`!=0; saturates at 32'hFFFF_FFFF; reset 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT);
  - hold-bit index constants HOLD_IF=0, HOLD_ID=1, HOLD_MEM=2;
  - hold encodings HOLD_NONE/HOLD_FRONT/HOLD_EX/HOLD_ALL (3'b000/001/011/111).
- One sub-module, mem_wait_fsm, contains the bus handshake FSM plus timeout counter. It outputs mem_stall, `bus_req_o` and `bus_err_o`; the top level does priority/hazard logic.

Test Plan:
- `mem_req_i`=1, `mem_ack_i`=1 in the same cycle -> `bus_req_o`=1, `flag_hold`=000, state stays RUN.
- `mem_req_i`=1, ack 3 cycles later -> `flag_hold`=111 for exactly 3 cycles, 000 on the ack cycle, `bus_err_o` never set.
- MEM_TIMEOUT=4, no ack -> hold 111 for 4 cycles, then `bus_err_o`=1 for one cycle with hold 000, back in RUN.
- `ex_mem_read_i`=1, `ex_rd_i`=5, `id_rs2_i`=5, `id_use_rs2_i`=1 -> `flag_hold`=001 and `flush_idex_o`=1 for one cycle; repeat with `ex_rd_i`=0 -> no hazard.
- lu and `branch_taken_i` together -> hold 000, both flushes 1; branch during MEM_WAIT -> 111 and no flush until the ack cycle.
- Reset pulsed at MEM_WAIT wait cycle 2 -> `bus_req_o` and `flag_hold` drop to 0 immediately; after release, RUN with counter 0. With HAZARD_STALL_CNT_EN, `stall_cycles_o` equals the count of hold cycles, 0 after reset.
